// File: rtl/piano_pkg.sv
// Shared definitions for the piano datapath: note codes, sequencer states and
// the layout of one song ROM entry.
package piano_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = 8;

  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seq_state_t;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Note-duration timer: a tick prescaler feeding a unit down-counter. `expired`
// is high during the final clock cycle of a loaded duration.
module beat_timer
  import piano_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] dur,
  output logic             expired
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick;
  logic [DUR_W-1:0]  unit;
  logic              tick_wrap;

  assign tick_wrap = (tick == TICK_LAST);
  assign expired   = (unit == DUR_W'(1)) && tick_wrap;

  // The timer free-runs only while units remain, then parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      unit <= '0;
    end else if (load) begin
      tick <= '0;
      unit <= dur;
    end else if (unit != '0) begin
      if (tick_wrap) begin
        tick <= '0;
        unit <= unit - DUR_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Owns the Buzzer note input: follows the live keyboard when idle, otherwise
// plays a song from a synchronous ROM with timed notes and articulation gaps.
module buzzer_sequencer
  import piano_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int ADDR_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NOTE_W-1:0]  key_note,
  input  logic               play_start,
  input  logic               play_stop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic [NOTE_W-1:0]  note_out,
  output logic               busy,
  output logic               song_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_t        state;
  seq_state_t        state_next;
  logic              start_pending;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_done;
  logic [ADDR_W-1:0] addr_next;
  logic [NOTE_W-1:0] note_next;
  logic              done_next;
  logic              timer_load;
  logic              timer_expired;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = entry_note(rom_data);
  assign rom_dur  = entry_dur(rom_data);
  assign gap_done = (gap_cnt == GAP_LAST);
  assign busy     = (state != ST_IDLE);

  beat_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_beat_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .dur     (rom_dur),
    .expired (timer_expired)
  );

  // play_start is registered, so FETCH begins one edge after the pulse is
  // sampled; a stop in the same cycle cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      start_pending <= 1'b0;
      rom_addr      <= '0;
      note_out      <= NOTE_REST;
      song_done     <= 1'b0;
      gap_cnt       <= '0;
    end else begin
      state         <= state_next;
      start_pending <= (state == ST_IDLE) && play_start && !play_stop;
      rom_addr      <= addr_next;
      note_out      <= note_next;
      song_done     <= done_next;
      gap_cnt       <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = rom_addr;
    note_next  = NOTE_REST;
    done_next  = 1'b0;
    timer_load = 1'b0;

    unique case (state)
      ST_IDLE: begin
        note_next = key_note;
        if (start_pending) begin
          state_next = ST_FETCH;
          addr_next  = '0;
          note_next  = NOTE_REST;
        end
      end
      ST_FETCH: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (rom_dur == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_PLAY;
          timer_load = 1'b1;
          note_next  = rom_note;
        end
      end
      ST_PLAY: begin
        note_next = note_out;
        if (timer_expired) begin
          state_next = ST_GAP;
          note_next  = NOTE_REST;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          if (rom_addr == ADDR_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_FETCH;
            addr_next  = rom_addr + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // An abort silences the output for one cycle before the keyboard takes over.
    if (play_stop && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
      addr_next  = rom_addr;
      note_next  = NOTE_REST;
      done_next  = 1'b0;
      timer_load = 1'b0;
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed, table-driven bench for buzzer_sequencer with a small synchronous
// song ROM model (TICK_DIV=4, GAP_CYCLES=2, ADDR_W=3).
module tb_buzzer_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int ADDR_W     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        key_note;
  logic              play_start;
  logic              play_stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [3:0]        note_out;
  logic              busy;
  logic              song_done;

  logic [7:0] rom_mem [0:7];

  typedef struct {
    logic [3:0] key;
    logic       start;
    logic       stop;
    logic [3:0] note;
    logic       busy;
    logic       done;
    logic       chk_addr;
    logic [2:0] addr;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  buzzer_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_note   (key_note),
    .play_start (play_start),
    .play_stop  (play_stop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_out   (note_out),
    .busy       (busy),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  // One-cycle read latency song ROM.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [3:0] key, input logic start, input logic stop,
                               input logic [3:0] note, input logic bsy, input logic done,
                               input logic chk_addr, input logic [2:0] addr);
    vec_t v;
    v.key = key; v.start = start; v.stop = stop;
    v.note = note; v.busy = bsy; v.done = done;
    v.chk_addr = chk_addr; v.addr = addr;
    vecs.push_back(v);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    key_note   = v.key;
    play_start = v.start;
    play_stop  = v.stop;
    @(posedge clk);
    #1;
    play_start = 1'b0;
    play_stop  = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("%s[%0d] note_out", tag, i), {4'd0, note_out}, {4'd0, vecs[i].note});
      check_output($sformatf("%s[%0d] busy", tag, i), {7'd0, busy}, {7'd0, vecs[i].busy});
      check_output($sformatf("%s[%0d] song_done", tag, i), {7'd0, song_done}, {7'd0, vecs[i].done});
      if (vecs[i].chk_addr)
        check_output($sformatf("%s[%0d] rom_addr", tag, i), {5'd0, rom_addr}, {5'd0, vecs[i].addr});
    end
    vecs.delete();
  endtask

  task automatic load_short_song();
    for (int i = 0; i < 8; i++) rom_mem[i] = 8'h00;
    rom_mem[0] = 8'h32;
    rom_mem[1] = 8'h51;
  endtask

  // Expected trace of the {0x32, 0x51, 0x00} song; full=0 stops after the
  // first cycle of the second gap.
  function automatic void fill_short_song(input logic [3:0] k, input bit full);
    push(k, 1, 0, k, 0, 0, 0, 0);
    push(k, 0, 0, 0, 1, 0, 1, 0);
    push(k, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) push(k, 0, 0, 4'd3, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) push(k, 0, 0, 0, 1, 0, 0, 0);
    push(k, 0, 0, 0, 1, 0, 1, 1);
    push(k, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(k, 0, 0, 4'd5, 1, 0, 0, 0);
    push(k, 0, 0, 0, 1, 0, 1, 1);
    if (full) begin
      push(k, 0, 0, 0, 1, 0, 0, 0);
      push(k, 0, 0, 0, 1, 0, 1, 2);
      push(k, 0, 0, 0, 1, 0, 0, 0);
      push(k, 0, 0, 0, 0, 1, 0, 0);
      push(k, 0, 0, k, 0, 0, 0, 0);
    end
  endfunction

  initial begin
    key_note   = 4'd0;
    play_start = 1'b0;
    play_stop  = 1'b0;
    rst_n      = 1'b0;
    load_short_song();

    repeat (2) @(posedge clk);
    #1;
    check_output("reset note_out", {4'd0, note_out}, 8'd0);
    check_output("reset busy", {7'd0, busy}, 8'd0);
    check_output("reset song_done", {7'd0, song_done}, 8'd0);
    check_output("reset rom_addr", {5'd0, rom_addr}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] keyboard follow in IDLE");
    push(4'd5, 0, 0, 4'd5, 0, 0, 0, 0);
    push(4'd0, 0, 0, 4'd0, 0, 0, 0, 0);
    run_table("idle");

    $display("[TB] short song, keyboard silent");
    fill_short_song(4'd0, 1);
    run_table("song0");

    $display("[TB] short song, key 9 held");
    fill_short_song(4'd9, 1);
    run_table("song9");

    $display("[TB] stop in third cycle of first note, then restart");
    push(4'd7, 1, 0, 4'd7, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd0, 1, 0, 1, 0);
    push(4'd7, 0, 0, 4'd0, 1, 0, 0, 0);
    push(4'd7, 0, 0, 4'd3, 1, 0, 0, 0);
    push(4'd7, 0, 0, 4'd3, 1, 0, 0, 0);
    push(4'd7, 0, 0, 4'd3, 1, 0, 0, 0);
    push(4'd7, 0, 1, 4'd0, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd7, 0, 0, 0, 0);
    push(4'd7, 1, 0, 4'd7, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd0, 1, 0, 1, 0);
    push(4'd7, 0, 0, 4'd0, 1, 0, 0, 0);
    push(4'd7, 0, 0, 4'd3, 1, 0, 0, 0);
    push(4'd7, 1, 1, 4'd0, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd7, 0, 0, 0, 0);
    push(4'd7, 1, 1, 4'd7, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd7, 0, 0, 0, 0);
    push(4'd7, 0, 0, 4'd7, 0, 0, 0, 0);
    run_table("stop");

    $display("[TB] full 8-entry ROM without terminator");
    for (int i = 0; i < 8; i++) rom_mem[i] = 8'((i + 1) * 16 + 1);
    push(4'd2, 1, 0, 4'd2, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      push(4'd2, 0, 0, 4'd0, 1, 0, 1, 3'(n));
      push(4'd2, 0, 0, 4'd0, 1, 0, 0, 0);
      for (int c = 0; c < 4; c++)
        push(4'd2, (n == 2 && c == 1), 0, 4'(n + 1), 1, 0, 0, 0);
      push(4'd2, 0, 0, 4'd0, 1, 0, 1, 3'(n));
      push(4'd2, 0, 0, 4'd0, 1, 0, 1, 3'(n));
    end
    push(4'd2, 0, 0, 4'd0, 0, 1, 1, 3'd7);
    push(4'd2, 0, 0, 4'd2, 0, 0, 1, 3'd7);
    run_table("full");

    $display("[TB] asynchronous reset during GAP");
    load_short_song();
    fill_short_song(4'd4, 0);
    run_table("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async rst note_out", {4'd0, note_out}, 8'd0);
    check_output("async rst busy", {7'd0, busy}, 8'd0);
    check_output("async rst rom_addr", {5'd0, rom_addr}, 8'd0);
    check_output("async rst song_done", {7'd0, song_done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(4'd4, 0, 0, 4'd4, 0, 0, 1, 0);
    push(4'd4, 0, 0, 4'd4, 0, 0, 1, 0);
    push(4'd4, 0, 0, 4'd4, 0, 0, 1, 0);
    run_table("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Controller that owns the 4-bit note input of the `Buzzer` tone generator and decides, every cycle, which note it plays. It arbitrates between live keyboard notes and an auto-play song read from a synchronous song ROM, timing each note's duration and inserting articulation gaps. The block sits between the key decoder / song ROM and `Buzzer`.

## Interface
- `TICK_DIV`, 25_000_000: clk cycles per duration unit (a quarter-second at 100 MHz).
- `GAP_CYCLES`, 1_000_000: cycles of forced silence after each song note; ≥1.
- `ADDR_W`, 6: song ROM address width.
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_note`  in  4  live keyboard note code; 0 means silence.
- `play_start`  in  1  single-cycle pulse that starts auto-play from address 0.
- `play_stop`  in  1  single-cycle pulse that aborts auto-play.
- `rom_addr`  out  ADDR_W  song ROM address.
- `rom_data`  in  8  ROM entry: [7:4] note code, [3:0] duration in units; the ROM has 1-cycle read latency.
- `note_out`  out  4  registered note code driven to `Buzzer`.
- `busy`  out  1  high while auto-play owns `note_out`.
- `song_done`  out  1  one-cycle pulse when a song ends normally.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: `note_out` <= `key_note` (1-cycle latency); `busy`=0. `play_start` -> FETCH with `rom_addr`=0.
- FETCH: `rom_addr` is stable; `note_out`=0. Always -> LOAD.
- LOAD: capture `rom_data`. If dur==0 (terminator) -> IDLE, pulse `song_done`. Else -> PLAY, load unit counter with dur.
- PLAY: `note_out` = captured note; note code 0 is a rest (silence). The block holds the note for exactly dur×TICK_DIV cycles, then -> GAP.
- GAP: `note_out`=0 for exactly GAP_CYCLES cycles. If `rom_addr` == 2^ADDR_W−1 -> IDLE with a `song_done` pulse, and no wrap. Else `rom_addr`+1 -> FETCH.
- `busy`=1 in every state except IDLE. `key_note` is ignored while busy.
- `play_stop` in any non-IDLE state -> IDLE on the next edge; `note_out` resumes following `key_note` one cycle later. No `song_done` pulse.
- `play_start` while busy is ignored. `play_start` and `play_stop` in the same cycle: stop wins, and in IDLE both are ignored.
- Counters: a tick counter counts 0..TICK_DIV−1 and a 4-bit unit counter decrements on tick wrap. The GAP counter is separate and sized to `$clog2(GAP_CYCLES+1)`.
- Reset values: state IDLE, `note_out`=0, `rom_addr`=0, `busy`=0, `song_done`=0, all counters 0.

## Timing
- Edge E0 samples `play_start`. E1 enters FETCH, E2 enters LOAD, and `note_out` shows the first note after E3.
- Silence between consecutive song notes is GAP_CYCLES+2 cycles (GAP, FETCH, LOAD).
- `song_done` is high for exactly the one cycle after the edge that enters IDLE from LOAD or GAP.
- Asynchronous reset mid-song returns all outputs to reset values immediately. After release, the block stays in IDLE until a new `play_start`.

## Structure
- Shared package `piano_pkg`: note code constants (`NOTE_REST`=4'd0), the state enum, the ROM entry field positions (`NOTE_MSB/LSB`, `DUR_MSB/LSB`) and the entry width.
- One natural sub-module, `beat_timer`: the tick counter plus unit counter. It takes `load`/`dur` inputs and raises a `expired` flag. It is reused by the future learning-mode scorer.

## Test plan
All scenarios use TICK_DIV=4, GAP_CYCLES=2, ADDR_W=3.
- Reset, then `key_note`=5 in IDLE -> `note_out`=5 one cycle later, `busy`=0. Changing to 0 gives `note_out`=0 next cycle.
- ROM {0x32, 0x51, 0x00} with `play_start` -> `note_out`=3 for 8 cycles, then 0 for 4 cycles, then 5 for 4 cycles. `song_done` pulses once, and `busy` falls the same cycle.
- Same song with `key_note`=9 held throughout -> `note_out` never shows 9 while busy, and shows 9 one cycle after `busy` falls.
- `play_stop` in the 3rd PLAY cycle of note 3 -> IDLE next edge, no `song_done`, `note_out`=`key_note` after one more cycle. Then `play_start` restarts from `rom_addr`=0.
- Full 8-entry ROM of 0x11..0x81 with no terminator -> 8 notes of 4 cycles each, then `song_done` after the last GAP, `rom_addr` not wrapped. A mid-song `play_start` is ignored, and a simultaneous start and stop aborts.
- `rst_n` asserted low asynchronously during GAP -> `note_out`=0, `busy`=0, `rom_addr`=0 before the next clk edge.
